cpu_cu: RTL and testbench
=========================

// Module: cpu_cu
// PURPOSE
//  Multi-cycle control unit for RISC16 CPU_EU. Decodes the IR word and sequences CPU_EU strobes
//  (ir_ld, pc_inc, pc_ld, we, s_sel) through fetch/decode/execute, with a memory-ready handshake,
//  free-run / single-step control and a memory watchdog. Sits beside CPU_EU in the CPU top.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on mem_rdy in one memory state; 0 = watchdog disabled
//  TO_W         5   watchdog counter width; requires 2**TO_W > MEM_TIMEOUT
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  run         in   1   1 = free-run; 0 = stop at next instruction boundary
//  step        in   1   in IDLE with run=0: start exactly one instruction (1-cycle pulse)
//  ir          in   16  CPU_EU instruction register; opcode = ir[15:12]
//  zero, neg   in   1   CPU_EU status flags, sampled in DECODE
//  mem_rdy     in   1   memory completes current read/write this cycle
//  ir_ld, pc_inc, pc_ld, we, s_sel  out 1  CPU_EU strobes; s_sel 0=ALU, 1=Din write-back
//  alu_op      out  3   ALU function = ir[14:12] in EXEC, else 0
//  addr_sel    out  1   Addr_Out source: 0=PC, 1=register operand
//  mem_rd, mem_wr out 1 memory request strobes
//  instr_done  out  1   1-cycle pulse on the last cycle of each instruction
//  halted, fault  out 1 sticky status; cleared only by rst
//  state       out  4   current FSM state (debug)
// BEHAVIOUR
//  - Opcodes: 0-7 ALU (ADD,SUB,AND,OR,XOR,NOT,SHL,SHR), 8 LD, 9 ST, A LDI, B JMP, C JZ, D JN, E NOP, F HLT.
//  - Outputs are Moore-decoded from state; strobes marked (*) are additionally ANDed with mem_rdy.
//  - rst: state=IDLE and every output 0 immediately (asynchronous), watchdog cleared.
//  - IDLE: no strobes. run=1 or step=1 -> FETCH.
//  - FETCH: mem_rd=1, addr_sel=0, ir_ld(*). On mem_rdy -> DECODE.
//  - DECODE: pc_inc=1 for exactly one cycle. Next: ALU->EXEC, LD->MEMRD, ST->MEMWR, LDI->IMM,
//    JMP->JUMP, JZ->JUMP if zero else BOUNDARY, JN->JUMP if neg else BOUNDARY, NOP->BOUNDARY, HLT->HALT.
//  - EXEC: we=1, s_sel=0, alu_op=ir[14:12] -> BOUNDARY.
//  - MEMRD: mem_rd=1, addr_sel=1, s_sel=1, we(*). On mem_rdy -> BOUNDARY.
//  - MEMWR: mem_wr=1, addr_sel=1. On mem_rdy -> BOUNDARY.
//  - IMM: mem_rd=1, addr_sel=0, s_sel=1, we(*), pc_inc(*). On mem_rdy -> BOUNDARY.
//  - JUMP: pc_ld=1 for one cycle -> BOUNDARY.
//  - BOUNDARY (not a state): instr_done=1 that cycle; next = FETCH if run else IDLE.
//  - HALT: halted=1, no strobes, holds until rst. FAULT: fault=1, no strobes, holds until rst.
//  - Watchdog: cleared on entry to FETCH/MEMRD/MEMWR/IMM; +1 per cycle with mem_rdy=0.
//    mem_rdy=0 with count==MEM_TIMEOUT-1 -> FAULT. mem_rdy=1 on that same cycle completes normally.
//  - Timing: ALU = 3 cycles (FETCH,DECODE,EXEC) at zero wait states; each wait cycle adds 1.
//  - run dropped mid-instruction: the instruction completes, then IDLE. step is ignored outside
//    IDLE or when run=1. step held high in IDLE behaves as run.
//  - mem_rd and mem_wr are never both 1; pc_ld and pc_inc are never both 1.
// STRUCTURE
//  - Shared package risc16_pkg (Verilog include risc16_defs.vh) holds opcode, ALU-op and
//    4-bit state-encoding constants; CPU_EU and the assembler tests use the same file.
//  - Sub-module cpu_cu_watchdog: clear/count/expire counter, params MEM_TIMEOUT, TO_W.
//  - cpu_cu holds the state register, next-state logic and output decode.
// TESTING
//  1. rst=1 mid-MEMRD -> all outputs 0 and state=IDLE before the next edge;
//     release with run=1, ir=0x1xxx (SUB), mem_rdy=1 -> ir_ld, pc_inc, then we=1 s_sel=0 alu_op=001
//     with instr_done, then FETCH.
//  2. LD, mem_rdy low 2 cycles in MEMRD -> MEMRD lasts 3 cycles; mem_rd=1, addr_sel=1, s_sel=1 throughout;
//     we=1 only in the 3rd cycle.
//  3. JZ: zero=0 -> DECODE then FETCH, no pc_ld; zero=1 -> JUMP with pc_ld=1 for exactly 1 cycle;
//     JN with neg=1 behaves the same.
//  4. run=0: one step pulse -> exactly one instr_done, then IDLE indefinitely;
//     run=0->1 mid-EXEC -> continues to FETCH.
//  5. MEM_TIMEOUT=4, mem_rdy=0 in FETCH -> FAULT after 4 cycles, fault=1 sticky, strobes 0;
//     mem_rdy=1 on the 4th cycle -> no fault.
//  6. LDI -> IMM with we=1, pc_inc=1, s_sel=1 on the mem_rdy cycle; HLT -> halted=1 held 100 cycles,
//     run/step ignored.

Source files
------------

// File: rtl/cpu_cu_pkg.sv
// Shared RISC16 control definitions: opcodes, ALU function codes,
// control-unit state encoding and small decode helpers.
package cpu_cu_pkg;

    // Instruction opcodes (ir[15:12])
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JN  = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU function codes driven on alu_op (ir[14:12] of an ALU opcode)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    // Control-unit states; IDLE must be zero so reset shows state 0
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_IMM    = 4'd6,
        ST_JUMP   = 4'd7,
        ST_HALT   = 4'd8,
        ST_FAULT  = 4'd9
    } state_t;

    // States that wait on the memory-ready handshake
    function automatic logic isMemState(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR) || (s == ST_IMM);
    endfunction

    // Opcodes 0-7 are register-to-register ALU operations
    function automatic logic isAluOp(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/cpu_cu_if.sv
// Control bundle between the control unit and the CPU_EU / memory side.
// The master side is the control unit; the slave side is whoever
// provides the instruction, flags and memory-ready.
interface cpu_cu_if;

    logic        run;
    logic        step;
    logic [15:0] ir;
    logic        zero;
    logic        neg;
    logic        mem_rdy;

    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic        we;
    logic        s_sel;
    logic [2:0]  alu_op;
    logic        addr_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        instr_done;
    logic        halted;
    logic        fault;
    logic [3:0]  state;

    modport master (
        input  run, step, ir, zero, neg, mem_rdy,
        output ir_ld, pc_inc, pc_ld, we, s_sel, alu_op, addr_sel,
               mem_rd, mem_wr, instr_done, halted, fault, state
    );

    modport slave (
        output run, step, ir, zero, neg, mem_rdy,
        input  ir_ld, pc_inc, pc_ld, we, s_sel, alu_op, addr_sel,
               mem_rd, mem_wr, instr_done, halted, fault, state
    );

endinterface

// File: rtl/cpu_cu_watchdog.sv
// Memory watchdog: counts wait cycles spent in one memory state and
// flags expiry on the wait cycle that would reach MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables expiry entirely.
module cpu_cu_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam bit              ENABLE = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] LIMIT  = ENABLE ? TO_W'(MEM_TIMEOUT - 1) : '0;

    logic [TO_W-1:0] r_count;

    // Wait-cycle counter: cleared on state entry, saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A wait cycle at the limit expires; a ready cycle never does
    always_comb begin
        o_expire = ENABLE && i_count && (r_count == LIMIT);
    end

endmodule

// File: rtl/cpu_cu.sv
// RISC16 multi-cycle control unit. Sequences CPU_EU strobes through
// fetch / decode / execute with a memory-ready handshake, run / single
// step control and a watchdog that traps stalled memory accesses.
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic     clk,
    input  logic     rst,
    cpu_cu_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_boundary;
    logic       w_expire;
    logic [3:0] w_opcode;

    assign w_opcode = bus.ir[15:12];

    cpu_cu_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_next != r_state),
        .i_count  (isMemState(r_state) && !bus.mem_rdy),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; w_boundary marks the last cycle of an instruction
    always_comb begin
        w_next     = r_state;
        w_boundary = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.run || bus.step) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_expire) begin
                    w_next = ST_FAULT;
                end else if (bus.mem_rdy) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (isAluOp(w_opcode)) begin
                    w_next = ST_EXEC;
                end else begin
                    case (w_opcode)
                        OP_LD:   w_next = ST_MEMRD;
                        OP_ST:   w_next = ST_MEMWR;
                        OP_LDI:  w_next = ST_IMM;
                        OP_JMP:  w_next = ST_JUMP;
                        OP_JZ: begin
                            if (bus.zero) w_next = ST_JUMP;
                            else          w_boundary = 1'b1;
                        end
                        OP_JN: begin
                            if (bus.neg) w_next = ST_JUMP;
                            else         w_boundary = 1'b1;
                        end
                        OP_HLT:  w_next = ST_HALT;
                        default: w_boundary = 1'b1;
                    endcase
                end
            end
            ST_EXEC, ST_JUMP: begin
                w_boundary = 1'b1;
            end
            ST_MEMRD, ST_MEMWR, ST_IMM: begin
                if (w_expire) begin
                    w_next = ST_FAULT;
                end else if (bus.mem_rdy) begin
                    w_boundary = 1'b1;
                end
            end
            ST_HALT:  w_next = ST_HALT;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
        if (w_boundary) begin
            w_next = bus.run ? ST_FETCH : ST_IDLE;
        end
    end

    // Output decode from state; memory-side write-back strobes wait for mem_rdy
    always_comb begin
        bus.ir_ld      = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_ld      = 1'b0;
        bus.we         = 1'b0;
        bus.s_sel      = 1'b0;
        bus.alu_op     = 3'd0;
        bus.addr_sel   = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.instr_done = w_boundary;
        bus.halted     = (r_state == ST_HALT);
        bus.fault      = (r_state == ST_FAULT);
        bus.state      = r_state;
        case (r_state)
            ST_FETCH: begin
                bus.mem_rd = 1'b1;
                bus.ir_ld  = bus.mem_rdy;
            end
            ST_DECODE: begin
                bus.pc_inc = 1'b1;
            end
            ST_EXEC: begin
                bus.we     = 1'b1;
                bus.alu_op = bus.ir[14:12];
            end
            ST_MEMRD: begin
                bus.mem_rd   = 1'b1;
                bus.addr_sel = 1'b1;
                bus.s_sel    = 1'b1;
                bus.we       = bus.mem_rdy;
            end
            ST_MEMWR: begin
                bus.mem_wr   = 1'b1;
                bus.addr_sel = 1'b1;
            end
            ST_IMM: begin
                bus.mem_rd = 1'b1;
                bus.s_sel  = 1'b1;
                bus.we     = bus.mem_rdy;
                bus.pc_inc = bus.mem_rdy;
            end
            ST_JUMP: begin
                bus.pc_ld = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_cu.sv
// Bench for the RISC16 control unit: each driven cycle pushes the
// hand-computed state and strobe vector into a scoreboard queue; a
// monitor on the falling edge pops and compares against the DUT.
module tb_cpu_cu;
    import cpu_cu_pkg::*;

    // Strobe vector layout: {ir_ld,pc_inc,pc_ld,we,s_sel,alu_op[2:0],addr_sel,mem_rd,mem_wr,instr_done,halted,fault}
    localparam logic [13:0] O_NONE = 14'h0000;
    localparam logic [13:0] IRLD   = 14'h2000;
    localparam logic [13:0] PCINC  = 14'h1000;
    localparam logic [13:0] PCLD   = 14'h0800;
    localparam logic [13:0] WE     = 14'h0400;
    localparam logic [13:0] SSEL   = 14'h0200;
    localparam logic [13:0] ADDR   = 14'h0020;
    localparam logic [13:0] MRD    = 14'h0010;
    localparam logic [13:0] MWR    = 14'h0008;
    localparam logic [13:0] DONE   = 14'h0004;
    localparam logic [13:0] HALTED = 14'h0002;
    localparam logic [13:0] FLT    = 14'h0001;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [13:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sbq[$];
    int   assertCount = 0;
    int   failCount   = 0;

    cpu_cu_if bus();

    cpu_cu #(
        .MEM_TIMEOUT (4),
        .TO_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] aluF(input logic [2:0] op);
        return {5'b00000, op, 6'b000000};
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what it must produce
    task automatic applyStimulus(input string name, input logic iRst, input logic iRun,
                                 input logic iStep, input logic [15:0] iIr, input logic iZero,
                                 input logic iNeg, input logic iRdy, input state_t eSt,
                                 input logic [13:0] eOut);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = iRst;
        bus.run     = iRun;
        bus.step    = iStep;
        bus.ir      = iIr;
        bus.zero    = iZero;
        bus.neg     = iNeg;
        bus.mem_rdy = iRdy;
        e.name = name;
        e.st   = eSt;
        e.out  = eOut;
        sbq.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic checkOutput();
        exp_t        e;
        logic [13:0] act;
        e   = sbq.pop_front();
        act = {bus.ir_ld, bus.pc_inc, bus.pc_ld, bus.we, bus.s_sel, bus.alu_op,
               bus.addr_sel, bus.mem_rd, bus.mem_wr, bus.instr_done, bus.halted, bus.fault};
        assertCount++;
        if ((act !== e.out) || (bus.state !== e.st)) begin
            failCount++;
            $display("[TB] FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                     e.name, bus.state, act, e.st, e.out);
        end
    endtask

    // Monitor samples on the falling edge, away from the state update
    always @(negedge clk) begin
        if (sbq.size() > 0) checkOutput();
    end

    initial begin
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.ir      = 16'h0000;
        bus.zero    = 1'b0;
        bus.neg     = 1'b0;
        bus.mem_rdy = 1'b0;

        // Reset, then async reset in the middle of a load
        applyStimulus("reset",         1, 0, 0, 16'h0000, 0, 0, 0, ST_IDLE,   O_NONE);
        applyStimulus("ld idle",       0, 1, 0, 16'h8000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("ld fetch",      0, 1, 0, 16'h8000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("ld decode",     0, 1, 0, 16'h8000, 0, 0, 0, ST_DECODE, PCINC);
        applyStimulus("ld memrd wait", 0, 1, 0, 16'h8000, 0, 0, 0, ST_MEMRD,  MRD | ADDR | SSEL);
        applyStimulus("rst mid memrd", 1, 1, 0, 16'h8000, 0, 0, 0, ST_IDLE,   O_NONE);

        // SUB after reset release
        applyStimulus("sub idle",      0, 1, 0, 16'h1234, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("sub fetch",     0, 1, 0, 16'h1234, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("sub decode",    0, 1, 0, 16'h1234, 0, 0, 1, ST_DECODE, PCINC);
        applyStimulus("sub exec",      0, 1, 0, 16'h1234, 0, 0, 1, ST_EXEC,   WE | aluF(3'd1) | DONE);

        // LD with two wait states
        applyStimulus("ld2 fetch",     0, 1, 0, 16'h8000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("ld2 decode",    0, 1, 0, 16'h8000, 0, 0, 0, ST_DECODE, PCINC);
        applyStimulus("ld2 memrd w1",  0, 1, 0, 16'h8000, 0, 0, 0, ST_MEMRD,  MRD | ADDR | SSEL);
        applyStimulus("ld2 memrd w2",  0, 1, 0, 16'h8000, 0, 0, 0, ST_MEMRD,  MRD | ADDR | SSEL);
        applyStimulus("ld2 memrd rdy", 0, 1, 0, 16'h8000, 0, 0, 1, ST_MEMRD,  MRD | ADDR | SSEL | WE | DONE);

        // Conditional jumps
        applyStimulus("jz0 fetch",     0, 1, 0, 16'hC000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("jz0 decode",    0, 1, 0, 16'hC000, 0, 0, 1, ST_DECODE, PCINC | DONE);
        applyStimulus("jz1 fetch",     0, 1, 0, 16'hC000, 1, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("jz1 decode",    0, 1, 0, 16'hC000, 1, 0, 1, ST_DECODE, PCINC);
        applyStimulus("jz1 jump",      0, 1, 0, 16'hC000, 1, 0, 1, ST_JUMP,   PCLD | DONE);
        applyStimulus("jn1 fetch",     0, 1, 0, 16'hD000, 0, 1, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("jn1 decode",    0, 1, 0, 16'hD000, 0, 1, 1, ST_DECODE, PCINC);
        applyStimulus("jn1 jump",      0, 1, 0, 16'hD000, 0, 1, 1, ST_JUMP,   PCLD | DONE);

        // run dropped: NOP completes, then IDLE; single step an ADD
        applyStimulus("nop fetch",     0, 0, 0, 16'hE000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("nop decode",    0, 0, 0, 16'hE000, 0, 0, 1, ST_DECODE, PCINC | DONE);
        applyStimulus("stop idle a",   0, 0, 0, 16'h0000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("stop idle b",   0, 0, 0, 16'h0000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("step pulse",    0, 0, 1, 16'h0000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("step fetch",    0, 0, 0, 16'h0000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("step decode",   0, 0, 0, 16'h0000, 0, 0, 1, ST_DECODE, PCINC);
        applyStimulus("step exec",     0, 0, 0, 16'h0000, 0, 0, 1, ST_EXEC,   WE | aluF(3'd0) | DONE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("step idle hold", 0, 0, 0, 16'h0000, 0, 0, 1, ST_IDLE, O_NONE);
        end

        // run raised mid-EXEC continues to FETCH; step outside IDLE ignored
        applyStimulus("or step",       0, 0, 1, 16'h3000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("or fetch",      0, 0, 0, 16'h3000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("or decode",     0, 0, 1, 16'h3000, 0, 0, 1, ST_DECODE, PCINC);
        applyStimulus("or exec run",   0, 1, 0, 16'h3000, 0, 0, 1, ST_EXEC,   WE | aluF(3'd3) | DONE);

        // LDI with one wait state, then ST with one wait state
        applyStimulus("ldi fetch",     0, 1, 0, 16'hA000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("ldi decode",    0, 1, 0, 16'hA000, 0, 0, 0, ST_DECODE, PCINC);
        applyStimulus("ldi imm wait",  0, 1, 0, 16'hA000, 0, 0, 0, ST_IMM,    MRD | SSEL);
        applyStimulus("ldi imm rdy",   0, 1, 0, 16'hA000, 0, 0, 1, ST_IMM,    MRD | SSEL | WE | PCINC | DONE);
        applyStimulus("st fetch",      0, 1, 0, 16'h9000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("st decode",     0, 1, 0, 16'h9000, 0, 0, 0, ST_DECODE, PCINC);
        applyStimulus("st memwr wait", 0, 1, 0, 16'h9000, 0, 0, 0, ST_MEMWR,  MWR | ADDR);
        applyStimulus("st memwr rdy",  0, 1, 0, 16'h9000, 0, 0, 1, ST_MEMWR,  MWR | ADDR | DONE);

        // Watchdog: ready on the 4th waiting cycle is still in time
        for (int i = 0; i < 3; i++) begin
            applyStimulus("wd fetch wait", 0, 1, 0, 16'hE000, 0, 0, 0, ST_FETCH, MRD);
        end
        applyStimulus("wd rdy 4th",    0, 1, 0, 16'hE000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("wd nop decode", 0, 1, 0, 16'hE000, 0, 0, 0, ST_DECODE, PCINC | DONE);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("wd expire wait", 0, 1, 0, 16'hE000, 0, 0, 0, ST_FETCH, MRD);
        end
        applyStimulus("fault entered", 0, 1, 1, 16'hE000, 0, 0, 1, ST_FAULT,  FLT);
        applyStimulus("fault sticky",  0, 0, 1, 16'h0000, 0, 0, 1, ST_FAULT,  FLT);

        // HLT holds for 100 cycles regardless of run/step
        applyStimulus("hlt reset",     1, 0, 0, 16'hF000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("hlt idle",      0, 1, 0, 16'hF000, 0, 0, 1, ST_IDLE,   O_NONE);
        applyStimulus("hlt fetch",     0, 1, 0, 16'hF000, 0, 0, 1, ST_FETCH,  IRLD | MRD);
        applyStimulus("hlt decode",    0, 1, 0, 16'hF000, 0, 0, 1, ST_DECODE, PCINC);
        for (int i = 0; i < 100; i++) begin
            applyStimulus("halt hold", 0, i[0], i[1], 16'h0000, 0, 0, 1, ST_HALT, HALTED);
        end

        @(negedge clk);
        #1;
        assertCount++;
        if (sbq.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
